fir_prog_seq: RTL and testbench

FIR_PROG_SEQ -- requirements
Module: fir_prog_seq

---
 rtl/fir_prog_seq.sv | 217 +++++++++++++++++++++
 tb/tb_fir_prog_seq.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_prog_seq.sv
// fir_prog_seq: reload sequencer for a programmable FIR filter.
//
// Streams 36-bit instructions into the filter's 9-bit program RAM (four
// words per instruction, low word first) while holding the filter in reset,
// then lets the filter's 4-stage internal reset pipeline drain before
// releasing it.
//
// Ports
//   clk        master clock (filter pclk and clk tie to it)
//   mrst_n     asynchronous active-low master reset
//   load       start-reload pulse, sampled only when idle
//   len        instruction count minus one, latched on load
//   dec_in     decimation modulus, latched on load
//   ncoef_in   coefficient count minus two, latched on load
//   abort      abandon an in-progress reload
//   ins        instruction {W, COEF[24:0], INDEX[9:0]}
//   ins_v      instruction valid
//   ins_rdy    instruction ready
//   pdata      program-RAM write word (0 whenever pwr=0)
//   pwr        program-RAM write strobe
//   prst       program-address counter reset
//   frst       filter master reset
//   dec        filter decimation modulus
//   ncoef      filter coefficient count minus two
//   busy       reload in progress
//   done       one-cycle reload-complete pulse
//   err        sticky error flag, cleared by the next accepted load
//
// Build option
//   FIR_AUTO_NCOEF_EN  when defined, ncoef is derived as len-1 at load and
//                      ncoef_in is ignored; len=0 flags err and gives ncoef=0.
//
// state | meaning
// IDLE  | waiting for load, filter running
// CLR   | one-cycle program-address counter reset
// WAIT  | ready for the next instruction
// SER   | four write cycles, one 9-bit word each
// FLUSH | four cycles of filter reset while its internal pipeline clears

module fir_prog_seq (
    input  logic        clk,
    input  logic        mrst_n,
    input  logic        load,
    input  logic [9:0]  len,
    input  logic [5:0]  dec_in,
    input  logic [9:0]  ncoef_in,
    input  logic        abort,
    input  logic [35:0] ins,
    input  logic        ins_v,
    output logic        ins_rdy,
    output logic [8:0]  pdata,
    output logic        pwr,
    output logic        prst,
    output logic        frst,
    output logic [5:0]  dec,
    output logic [9:0]  ncoef,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_WAIT,
        ST_SER,
        ST_FLUSH
    } state_t;

    state_t      state_q;
    logic [9:0]  rem_q;       // instructions still to write after the current one
    logic        term_q;      // current instruction is the last one
    logic [26:0] sh_q;        // upper three words of the captured instruction
    logic [1:0]  k_q;         // word index within SER
    logic [1:0]  fl_q;        // FLUSH cycles remaining minus one
    logic        from_ser_q;  // FLUSH entered from a completed reload

    logic        ins_rdy_q;
    logic        pwr_q;
    logic [8:0]  pdata_q;
    logic        prst_q;
    logic        frst_q;
    logic        done_q;
    logic        err_q;
    logic [5:0]  dec_q;
    logic [9:0]  ncoef_q;

    logic [9:0]  ncoef_d;
    logic        err_d;
    logic        abort_act;

`ifdef FIR_AUTO_NCOEF_EN
    always_comb begin
        ncoef_d = (len == 10'd0) ? 10'd0 : len - 10'd1;
        err_d   = (len == 10'd0);
    end
`else
    always_comb begin
        ncoef_d = ncoef_in;
        err_d   = 1'b0;
    end
`endif

    // abort only matters while a reload is actually moving data
    assign abort_act = abort &&
                       ((state_q == ST_CLR) || (state_q == ST_WAIT) || (state_q == ST_SER));

    always_ff @(posedge clk or negedge mrst_n) begin
        if (!mrst_n) begin
            state_q    <= ST_FLUSH;
            fl_q       <= 2'd3;
            k_q        <= 2'd0;
            rem_q      <= 10'd0;
            term_q     <= 1'b0;
            sh_q       <= 27'd0;
            from_ser_q <= 1'b0;
            ins_rdy_q  <= 1'b0;
            pwr_q      <= 1'b0;
            pdata_q    <= 9'd0;
            prst_q     <= 1'b0;
            frst_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            dec_q      <= 6'd1;
            ncoef_q    <= 10'd0;
        end else begin
            // strobes default low; pdata follows pwr to zero
            ins_rdy_q <= 1'b0;
            pwr_q     <= 1'b0;
            pdata_q   <= 9'd0;
            prst_q    <= 1'b0;
            done_q    <= 1'b0;

            if (abort_act) begin
                state_q    <= ST_FLUSH;
                fl_q       <= 2'd3;
                from_ser_q <= 1'b0;
                err_q      <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (load) begin
                            rem_q      <= len;
                            term_q     <= (len == 10'd0);
                            dec_q      <= dec_in;
                            ncoef_q    <= ncoef_d;
                            err_q      <= err_d;
                            frst_q     <= 1'b1;
                            prst_q     <= 1'b1;
                            from_ser_q <= 1'b0;
                            state_q    <= ST_CLR;
                        end
                    end
                    ST_CLR: begin
                        ins_rdy_q <= 1'b1;
                        state_q   <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (ins_v && ins_rdy_q) begin
                            sh_q    <= ins[35:9];
                            pdata_q <= ins[8:0];
                            pwr_q   <= 1'b1;
                            k_q     <= 2'd0;
                            state_q <= ST_SER;
                        end else begin
                            ins_rdy_q <= 1'b1;
                        end
                    end
                    ST_SER: begin
                        if (k_q != 2'd3) begin
                            k_q     <= k_q + 2'd1;
                            pwr_q   <= 1'b1;
                            pdata_q <= sh_q[8:0];
                            sh_q    <= {9'd0, sh_q[26:9]};
                        end else if (term_q) begin
                            state_q    <= ST_FLUSH;
                            fl_q       <= 2'd3;
                            from_ser_q <= 1'b1;
                        end else begin
                            // down-count stops at the terminal flag, so len=1023 never wraps
                            rem_q     <= rem_q - 10'd1;
                            term_q    <= (rem_q == 10'd1);
                            ins_rdy_q <= 1'b1;
                            state_q   <= ST_WAIT;
                        end
                    end
                    ST_FLUSH: begin
                        if (fl_q == 2'd0) begin
                            state_q    <= ST_IDLE;
                            frst_q     <= 1'b0;
                            done_q     <= from_ser_q;
                            from_ser_q <= 1'b0;
                        end else begin
                            fl_q <= fl_q - 2'd1;
                        end
                    end
                    default: begin
                        state_q <= ST_FLUSH;
                        fl_q    <= 2'd3;
                    end
                endcase
            end
        end
    end

    assign ins_rdy = ins_rdy_q;
    assign pdata   = pdata_q;
    assign pwr     = pwr_q;
    assign prst    = prst_q;
    assign frst    = frst_q;
    assign dec     = dec_q;
    assign ncoef   = ncoef_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_fir_prog_seq.sv
`timescale 1ns/1ps
module tb_fir_prog_seq;

    logic        clk = 1'b0;
    logic        mrst_n = 1'b1;
    logic        load = 1'b0;
    logic [9:0]  len = 10'd0;
    logic [5:0]  dec_in = 6'd0;
    logic [9:0]  ncoef_in = 10'd0;
    logic        abort = 1'b0;
    logic [35:0] ins = 36'd0;
    logic        ins_v = 1'b0;
    logic        ins_rdy;
    logic [8:0]  pdata;
    logic        pwr, prst, frst, busy, done, err;
    logic [5:0]  dec;
    logic [9:0]  ncoef;

    fir_prog_seq dut (
        .clk(clk), .mrst_n(mrst_n), .load(load), .len(len), .dec_in(dec_in),
        .ncoef_in(ncoef_in), .abort(abort), .ins(ins), .ins_v(ins_v),
        .ins_rdy(ins_rdy), .pdata(pdata), .pwr(pwr), .prst(prst), .frst(frst),
        .dec(dec), .ncoef(ncoef), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit model_err = 1'b0;

    logic [35:0] words_q[$];
    logic [8:0]  exp_q[$];

    // observation of the DUT, one sample per cycle on the falling edge
    bit          mon_en = 1'b0;
    logic [8:0]  got_q[$];
    int done_cnt, prst_cnt, busy_cnt, tail, v_pdata, v_rdy_pwr, v_rdy_hold, v_prst_late;
    bit prev_hold;

    always @(negedge clk) begin
        if (mon_en) begin
            if (pwr) begin
                got_q.push_back(pdata);
                tail = 0;
            end else begin
                if (pdata !== 9'd0) v_pdata++;
                if (frst) tail++;
            end
            if (done) done_cnt++;
            if (prst) begin
                prst_cnt++;
                if (got_q.size() != 0) v_prst_late++;
            end
            if (busy) busy_cnt++;
            if (ins_rdy && pwr) v_rdy_pwr++;
            if (prev_hold && !ins_rdy) v_rdy_hold++;
            prev_hold = ins_rdy && !ins_v && !abort && mrst_n;
        end
    end

    task automatic mon_clear();
        got_q.delete();
        done_cnt = 0; prst_cnt = 0; busy_cnt = 0; tail = 0;
        v_pdata = 0; v_rdy_pwr = 0; v_rdy_hold = 0; v_prst_late = 0;
        prev_hold = 1'b0;
    endtask

    function automatic logic [9:0] exp_ncoef(logic [9:0] l, logic [9:0] n);
`ifdef FIR_AUTO_NCOEF_EN
        return (l == 10'd0) ? 10'd0 : l - 10'd1;
`else
        return n;
`endif
    endfunction

    function automatic bit exp_err_load(logic [9:0] l);
`ifdef FIR_AUTO_NCOEF_EN
        return (l == 10'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic wait_idle(int budget, string tag);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_timeout busy=%b expected 0", tag, busy);
        end
    endtask

    // source model: presents words_q in order, optional gap after each accept,
    // optional abort in the 2nd write cycle of instruction abort_idx,
    // optional load pulse halfway through the reload
    task automatic feed(int gap, int abort_idx, bit mid_load, output bit timed_out);
        int idx = 0;
        int gapc = 0;
        int budget;
        bit fire;
        bit ml_done = 1'b0;
        budget = (gap + 8) * (words_q.size() + 2) + 50;
        timed_out = 1'b0;
        ins = words_q[0];
        ins_v = 1'b1;
        while (idx < words_q.size()) begin
            if (budget == 0) begin
                timed_out = 1'b1;
                break;
            end
            budget--;
            @(negedge clk);
            fire = ins_v && ins_rdy;
            @(posedge clk); #1;
            load = 1'b0;
            if (fire) begin
                if (idx == abort_idx) begin
                    ins_v = 1'b0;
                    @(posedge clk); #1;
                    abort = 1'b1;
                    @(posedge clk); #1;
                    abort = 1'b0;
                    break;
                end
                idx++;
                ins_v = 1'b0;
                gapc = gap;
            end
            if (mid_load && !ml_done && idx == words_q.size() / 2) begin
                load = 1'b1;
                len = 10'd3;
                dec_in = ~dec_in;
                ml_done = 1'b1;
            end
            if (!ins_v && idx < words_q.size()) begin
                if (gapc == 0) begin
                    ins_v = 1'b1;
                    ins = words_q[idx];
                end else begin
                    gapc--;
                end
            end
        end
        ins_v = 1'b0;
        load = 1'b0;
    endtask

    task automatic run_reload(int l, int gap, int abort_idx, bit fix0, bit mid_load,
                              bit flush_abort, string tag);
        logic [5:0]  d;
        logic [9:0]  n;
        logic [35:0] w;
        bit to;
        bit exp_err;
        int exp_words;
        int bad;
        words_q.delete();
        exp_q.delete();
        for (int i = 0; i <= l; i++) begin
            w[31:0]  = $urandom;
            w[35:32] = 4'($urandom_range(0, 15));
            if (fix0 && i == 0) w = 36'h8_0000_0001;
            words_q.push_back(w);
            for (int j = 0; j < 4; j++) exp_q.push_back(w[9*j +: 9]);
        end
        exp_words = (abort_idx >= 0) ? 4 * abort_idx + 2 : 4 * (l + 1);
        exp_err = (abort_idx >= 0) || exp_err_load(10'(l));

        mon_clear();
        mon_en = 1'b1;
        d = 6'($urandom_range(0, 63));
        n = 10'($urandom_range(0, 1023));
        @(posedge clk); #1;
        load = 1'b1; len = 10'(l); dec_in = d; ncoef_in = n;
        @(posedge clk); #1;
        load = 1'b0;
        len = 10'($urandom_range(0, 1023));
        dec_in = 6'($urandom_range(0, 63));
        ncoef_in = 10'($urandom_range(0, 1023));

        checks++;
        if (dec !== d) begin failures++; $display("FAIL %s dec_at_load got=%h exp=%h", tag, dec, d); end
        checks++;
        if (ncoef !== exp_ncoef(10'(l), n)) begin
            failures++; $display("FAIL %s ncoef_at_load got=%h exp=%h", tag, ncoef, exp_ncoef(10'(l), n));
        end
        checks++;
        if ({frst, prst, busy} !== 3'b111) begin
            failures++; $display("FAIL %s frst_prst_busy_at_load got=%b exp=111", tag, {frst, prst, busy});
        end
        checks++;
        if (err !== exp_err_load(10'(l))) begin
            failures++; $display("FAIL %s err_at_load got=%b exp=%b", tag, err, exp_err_load(10'(l)));
        end

        feed(gap, abort_idx, mid_load, to);
        checks++;
        if (to) begin failures++; $display("FAIL %s feed_timeout got=1 exp=0", tag); end

        if (flush_abort) begin
            repeat (4) @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end

        wait_idle(200, tag);
        repeat (2) @(negedge clk);
        mon_en = 1'b0;

        checks++;
        if (got_q.size() != exp_words) begin
            failures++; $display("FAIL %s pwr_count got=%0d exp=%0d", tag, got_q.size(), exp_words);
        end
        bad = -1;
        for (int i = 0; i < exp_words && i < got_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++; $display("FAIL %s pdata[%0d] got=%h exp=%h", tag, bad, got_q[bad], exp_q[bad]);
        end
        checks++;
        if (done_cnt != ((abort_idx >= 0) ? 0 : 1)) begin
            failures++; $display("FAIL %s done_count got=%0d exp=%0d", tag, done_cnt, (abort_idx >= 0) ? 0 : 1);
        end
        checks++;
        if (err !== exp_err) begin failures++; $display("FAIL %s err_end got=%b exp=%b", tag, err, exp_err); end
        checks++;
        if (tail != 4) begin failures++; $display("FAIL %s flush_frst_cycles got=%0d exp=4", tag, tail); end
        checks++;
        if (v_pdata != 0) begin failures++; $display("FAIL %s pdata_nonzero_no_pwr got=%0d exp=0", tag, v_pdata); end
        checks++;
        if (v_rdy_pwr != 0) begin failures++; $display("FAIL %s rdy_with_pwr got=%0d exp=0", tag, v_rdy_pwr); end
        checks++;
        if (v_rdy_hold != 0) begin failures++; $display("FAIL %s rdy_dropped_waiting got=%0d exp=0", tag, v_rdy_hold); end
        checks++;
        if (prst_cnt != 1 || v_prst_late != 0) begin
            failures++; $display("FAIL %s prst_cycles got=%0d late=%0d exp=1/0", tag, prst_cnt, v_prst_late);
        end
        checks++;
        if ({frst, dec} !== {1'b0, d}) begin
            failures++; $display("FAIL %s frst_dec_end got=%b/%h exp=0/%h", tag, frst, dec, d);
        end
        if (gap == 0 && abort_idx < 0) begin
            checks++;
            if (busy_cnt != 5 * (l + 1) + 5) begin
                failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", tag, busy_cnt, 5 * (l + 1) + 5);
            end
        end
        model_err = exp_err;
    endtask

    localparam logic [31:0] RST_VEC = {1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1, 10'd0};

    task automatic test_reset();
        int fcnt = 0;
        int dcnt = 0;
        #1 mrst_n = 1'b0;
        #1;
        checks++;
        if ({frst, prst, pwr, pdata, ins_rdy, busy, done, err, dec, ncoef} !== RST_VEC) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", {frst, prst, pwr, pdata, ins_rdy, busy, done, err, dec, ncoef}, RST_VEC);
        end
        @(posedge clk); #1;
        mrst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (frst) fcnt++;
            if (done) dcnt++;
        end
        checks++;
        if (fcnt != 4) begin failures++; $display("FAIL reset_frst_cycles got=%0d exp=4", fcnt); end
        checks++;
        if (dcnt != 0) begin failures++; $display("FAIL reset_done got=%0d exp=0", dcnt); end
        checks++;
        if ({busy, frst, err} !== 3'b000) begin
            failures++; $display("FAIL reset_idle got=%b exp=000", {busy, frst, err});
        end
        model_err = 1'b0;
    endtask

    task automatic test_directed();
        run_reload(2, 0, -1, 1'b1, 1'b0, 1'b0, "directed_len2");
        checks++;
        if (got_q.size() < 4 || {got_q[0], got_q[1], got_q[2], got_q[3]} !== {9'h001, 9'h000, 9'h000, 9'h100}) begin
            failures++;
            $display("FAIL directed_first_words got_count=%0d exp=001,000,000,100", got_q.size());
        end
    endtask

    task automatic test_ncoef();
        logic [9:0] exp_n;
`ifdef FIR_AUTO_NCOEF_EN
        exp_n = 10'd8;
`else
        exp_n = 10'h3FE;
`endif
        @(posedge clk); #1;
        load = 1'b1; len = 10'd9; dec_in = 6'd5; ncoef_in = 10'h3FE;
        @(posedge clk); #1;
        load = 1'b0;
        abort = 1'b1;
        checks++;
        if (ncoef !== exp_n) begin failures++; $display("FAIL ncoef_select got=%h exp=%h", ncoef, exp_n); end
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle(50, "ncoef");
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL ncoef_abort_err got=%b exp=1", err); end
        model_err = 1'b1;
    endtask

    task automatic test_gapped();
        run_reload($urandom_range(3, 6), 7, -1, 1'b0, 1'b0, 1'b0, "gapped");
    endtask

    task automatic test_abort();
        run_reload(8, 0, 4, 1'b0, 1'b0, 1'b0, "abort_ser");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++)
            run_reload($urandom_range(0, 5), $urandom_range(0, 3), -1, 1'b0, 1'b0, 1'b0, "random");
    endtask

    task automatic test_ignore();
        @(posedge clk); #1;
        abort = 1'b1;
        repeat (3) @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, frst, prst, pwr, err} !== {4'b0000, model_err}) begin
            failures++;
            $display("FAIL idle_abort got=%b exp=%b", {busy, frst, prst, pwr, err}, {4'b0000, model_err});
        end
        run_reload(2, 0, -1, 1'b0, 1'b0, 1'b1, "flush_abort");
    endtask

    task automatic test_long();
        run_reload(1023, 0, -1, 1'b0, 1'b1, 1'b0, "long_1023");
    endtask

    task automatic test_mid_reset();
        int n = 0;
        mon_clear();
        mon_en = 1'b1;
        @(posedge clk); #1;
        load = 1'b1; len = 10'd5; dec_in = 6'd9; ncoef_in = 10'd3;
        @(posedge clk); #1;
        load = 1'b0;
        ins = {4'($urandom_range(0, 15)), 32'($urandom)};
        ins_v = 1'b1;
        @(negedge clk);
        while (!pwr && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pwr !== 1'b1) begin failures++; $display("FAIL midreset_reach_ser got=%b exp=1", pwr); end
        @(posedge clk); #3;
        mrst_n = 1'b0;
        #1;
        checks++;
        if ({frst, prst, pwr, pdata, ins_rdy, busy, done, err, dec, ncoef} !== RST_VEC) begin
            failures++;
            $display("FAIL midreset_values got=%h exp=%h", {frst, prst, pwr, pdata, ins_rdy, busy, done, err, dec, ncoef}, RST_VEC);
        end
        ins_v = 1'b0;
        @(posedge clk); #1;
        mrst_n = 1'b1;
        wait_idle(20, "midreset");
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (done_cnt != 0 || frst !== 1'b0) begin
            failures++; $display("FAIL midreset_done got=%0d/frst=%b exp=0/0", done_cnt, frst);
        end
        model_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ncoef();
        test_gapped();
        test_abort();
        test_random();
        test_ignore();
        test_long();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
